// File: rtl/sn_pkg.sv
// Shared types and default sizing for the stochastic-number stream generator.
// Used by sn_stream_gen, its interface and its select decoder.
package sn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } sn_state_e;

    localparam int SN_N_CH_DEF = 4;
    localparam int SN_B_W_DEF  = 4;

endpackage

// File: rtl/sn_stream_gen_if.sv
// Handshake and data bundle of sn_stream_gen; the generator sits on the slave modport.
// o_pop_cnt only exists when SN_STREAM_POPCOUNT_EN is defined.
interface sn_stream_gen_if
    import sn_pkg::*;
#(
    parameter int N_CH = SN_N_CH_DEF,
    parameter int B_W  = SN_B_W_DEF
);

    logic [N_CH-1:0][B_W-1:0] i_x_bn;
    logic                     i_start;
    logic                     i_abort;
    logic                     o_ready;
    logic                     o_isgen;
    logic [N_CH-1:0]          o_sn_bit;
    logic                     o_done;
    logic                     o_aborted;
`ifdef SN_STREAM_POPCOUNT_EN
    logic [N_CH-1:0][B_W:0]   o_pop_cnt;
`endif

    modport slave (
`ifdef SN_STREAM_POPCOUNT_EN
        output o_pop_cnt,
`endif
        input  i_x_bn, i_start, i_abort,
        output o_ready, o_isgen, o_sn_bit, o_done, o_aborted
    );

    modport master (
`ifdef SN_STREAM_POPCOUNT_EN
        input  o_pop_cnt,
`endif
        output i_x_bn, i_start, i_abort,
        input  o_ready, o_isgen, o_sn_bit, o_done, o_aborted
    );

endinterface

// File: rtl/sn_sel_decode.sv
// Maps cycle counter t to the operand bit index B_W-1-ctz(t+1).
// For t = all-ones the index is meaningless; the top forces the stream bit to 0 there.
module sn_sel_decode
    import sn_pkg::*;
#(
    parameter int B_W = SN_B_W_DEF
) (
    input  logic [B_W-1:0] t,
    output logic [B_W-1:0] sel
);

    logic [B_W-1:0] t_inc;

    assign t_inc = t + B_W'(1);

    // Scanning from MSB down lets the lowest set bit win, i.e. the trailing-zero count.
    always_comb begin
        sel = '0;
        for (int i = B_W - 1; i >= 0; i--) begin
            if (t_inc[i]) begin
                sel = B_W'(B_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/sn_stream_gen.sv
// Multi-channel binary-to-stochastic stream generator: L = 2^B_W bits per operand.
// Define SN_STREAM_POPCOUNT_EN to add the per-channel emitted-ones counters (o_pop_cnt).
module sn_stream_gen
    import sn_pkg::*;
#(
    parameter int N_CH = SN_N_CH_DEF,
    parameter int B_W  = SN_B_W_DEF
) (
    input  logic             i_clk_fsm_mux,
    input  logic             i_rst_fsm_mux,
    sn_stream_gen_if.slave   bus
);

    sn_state_e                state;
    sn_state_e                state_nxt;
    logic [B_W-1:0]           t;
    logic [B_W-1:0]           sel;
    logic [N_CH-1:0][B_W-1:0] x_reg;
    logic [N_CH-1:0]          sn_bit;
    logic                     aborted_q;
    logic                     accept;
    logic                     last;

    assign accept = bus.i_start && (state == IDLE);
    assign last   = &t;

    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort takes priority over the final-cycle transition so a late abort never yields o_done.
    always_comb begin
        state_nxt   = state;
        bus.o_ready = 1'b0;
        bus.o_isgen = 1'b0;
        bus.o_done  = 1'b0;
        case (state)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_start) begin
                    state_nxt = GEN;
                end
            end
            GEN: begin
                bus.o_isgen = 1'b1;
                if (bus.i_abort) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.o_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux) begin
            t         <= '0;
            x_reg     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= (state == GEN) && bus.i_abort;
            if (accept) begin
                t     <= '0;
                x_reg <= bus.i_x_bn;
            end else if (state == GEN) begin
                t <= t + B_W'(1);
            end
        end
    end

    sn_sel_decode #(.B_W(B_W)) u_sel_decode (
        .t   (t),
        .sel (sel)
    );

    // The final cycle emits 0 so each channel produces exactly x_reg[c] ones.
    always_comb begin
        sn_bit = '0;
        if ((state == GEN) && !last) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int b = 0; b < B_W; b++) begin
                    if (sel == B_W'(b)) begin
                        sn_bit[c] = x_reg[c][b];
                    end
                end
            end
        end
    end

    assign bus.o_sn_bit  = sn_bit;
    assign bus.o_aborted = aborted_q;

`ifdef SN_STREAM_POPCOUNT_EN
    logic [N_CH-1:0][B_W:0] pop_cnt;

    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux) begin
            pop_cnt <= '0;
        end else if (accept) begin
            pop_cnt <= '0;
        end else if (state == GEN) begin
            for (int c = 0; c < N_CH; c++) begin
                pop_cnt[c] <= pop_cnt[c] + (B_W + 1)'(sn_bit[c]);
            end
        end
    end

    assign bus.o_pop_cnt = pop_cnt;
`endif

endmodule

// File: doc/sn_stream_gen.md
SN_STREAM_GEN -- requirements
Module: sn_stream_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of parallel channels (1..16).
REQ-002 SHALL have parameter B_W, default 4, operand width; stream length L = 2^B_W (B_W 2..8).
REQ-003 SHALL have port i_clk_fsm_mux  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_fsm_mux  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_x_bn  in  N_CH x B_W  unsigned binary operands, one per channel.
REQ-006 SHALL have port i_start  in  1  request; accepted when i_start and o_ready are both high.
REQ-007 SHALL have port i_abort  in  1  terminates the stream in progress.
REQ-008 SHALL have port o_ready  out  1  high only in IDLE.
REQ-009 SHALL have port o_isgen  out  1  high while stream bits are valid.
REQ-010 SHALL have port o_sn_bit  out  N_CH  current stochastic bit per channel.
REQ-011 SHALL have port o_done  out  1  one-cycle pulse after a full stream of L bits.
REQ-012 SHALL have port o_aborted  out  1  one-cycle pulse after an abort.

Function
REQ-013 SHALL capture i_x_bn into an internal register on the accepting edge; later input changes SHALL NOT affect the stream.
REQ-014 SHALL implement states IDLE, GEN, DONE; IDLE->GEN on accept; GEN->DONE when t = L-1; GEN->IDLE on i_abort; DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL hold a B_W-bit cycle counter t, cleared to 0 on accept and incremented each GEN cycle.
REQ-016 SHALL, in GEN with t < L-1, drive o_sn_bit[c] = x_reg[c][B_W-1-ctz(t+1)], ctz = count of trailing zeros.
REQ-017 SHALL drive o_sn_bit = 0 in GEN at t = L-1, so each channel emits exactly x_reg[c] ones over L cycles.
REQ-018 SHALL assert o_isgen exactly in GEN; the first bit appears in the cycle after accept (latency 1); o_sn_bit SHALL be 0 outside GEN.
REQ-019 SHALL pulse o_done in the DONE cycle only; o_ready SHALL be low in GEN and DONE.
REQ-020 SHALL, when i_abort is high in GEN (including at t = L-1), go to IDLE next cycle, pulse o_aborted in that IDLE cycle, and NOT pulse o_done.
REQ-021 SHALL ignore i_abort in IDLE and DONE; i_start and i_abort both high in IDLE SHALL start a stream.
REQ-022 SHALL ignore i_start while o_ready is low; no queuing.

Reset
REQ-023 SHALL on reset, at any time including mid-stream, force IDLE, t = 0, x_reg = 0, o_ready = 1, and o_isgen, o_sn_bit, o_done, o_aborted = 0.
REQ-024 SHALL accept a start on the first rising edge after reset deassertion.

Configuration
REQ-025 SHALL, with SN_STREAM_POPCOUNT_EN defined, add output o_pop_cnt (N_CH x (B_W+1)), per-channel count of emitted ones, cleared on accept, held from DONE until the next accept.
REQ-026 SHALL, without SN_STREAM_POPCOUNT_EN, omit o_pop_cnt and all counter logic; other behaviour identical.

Structure
REQ-027 SHALL take state enum (IDLE, GEN, DONE) and default N_CH/B_W constants from shared package sn_pkg.
REQ-028 SHALL place the ctz-based select decode in sub-module sn_sel_decode (t in, B_W-bit index out), combinational, one instance shared by all channels.

Verification
REQ-029 SHALL cover N_CH=4, B_W=4, x=4'b1010 on ch0 -> ch0 stream 1,0,1,1,1,0,1,0,1,0,1,1,1,0,1,0; o_done at cycle 17 after accept.
REQ-030 SHALL cover x = 0 and x = 15 -> 0 ones and 15 ones in 16 cycles; with POPCOUNT_EN o_pop_cnt = 0 and 15.
REQ-031 SHALL cover i_abort at t = 5 -> o_isgen low next cycle, o_aborted pulses once, no o_done.
REQ-032 SHALL cover i_x_bn changing and i_start pulsing during GEN -> stream unchanged, no restart.
REQ-033 SHALL cover reset asserted at t = 8 -> all outputs 0 immediately, o_ready = 1; new start gives a full correct stream.
REQ-034 SHALL cover B_W=8, N_CH=1, x=200 -> 200 ones in 256 cycles, bit 0 at t = 255.
